// File: rtl/lc3_mem_ctrl_if.sv
// CPU-side memory bus of the LC-3 controller: CS/WE strobe, MAR address, MDR data, READY pulse.
interface lc3_mem_ctrl_if;
    logic        CS;
    logic        WE;
    logic [15:0] ADDR;
    logic [15:0] DataIn;
    logic [15:0] DataOut;
    logic        READY;

    modport master (output CS, WE, ADDR, DataIn, input DataOut, READY);
    modport slave  (input CS, WE, ADDR, DataIn, output DataOut, READY);
endinterface

// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory/IO controller: sequences RAM accesses with wait states and owns the
// keyboard/display registers of the I/O page.
module lc3_mem_ctrl #(
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [15:0] IO_BASE     = 16'hFE00
) (
    input  logic          CLK,
    input  logic          RST,
    lc3_mem_ctrl_if.slave cpu,
    output logic          ram_en,
    output logic          ram_we,
    output logic [15:0]   ram_addr,
    output logic [15:0]   ram_din,
    input  logic [15:0]   ram_dout,
    input  logic          kb_valid,
    input  logic [7:0]    kb_data,
    output logic          dsp_valid,
    output logic [7:0]    dsp_data,
    input  logic          dsp_ready
);
    localparam logic [15:0] AddrKbsr = IO_BASE;
    localparam logic [15:0] AddrKbdr = IO_BASE + 16'd2;
    localparam logic [15:0] AddrDsr  = IO_BASE + 16'd4;
    localparam logic [15:0] AddrDdr  = IO_BASE + 16'd6;

    typedef enum logic [1:0] {StIdle, StRamWait, StResp} state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [15:0] addr_q, wdata_q, data_out_q;
    logic        we_q, io_q, cap_q, ready_q;
    logic        ram_en_q, ram_we_q;
    logic [15:0] ram_addr_q, ram_din_q;
    logic [7:0]  kbdr_q, dsp_data_q;
    logic        kb_full_q, dsp_valid_q;
    logic [15:0] io_rdata;
    logic        kbdr_rd, ddr_wr;

    always_comb begin
        io_rdata = 16'h0000;
        case (addr_q)
            AddrKbsr: io_rdata = {kb_full_q, 15'b0};
            AddrKbdr: io_rdata = {8'h00, kbdr_q};
            AddrDsr:  io_rdata = {~dsp_valid_q, 15'b0};
            default:  io_rdata = 16'h0000;
        endcase
    end

    assign kbdr_rd = (state_q == StResp) && io_q && !we_q && (addr_q == AddrKbdr);
    assign ddr_wr  = (state_q == StResp) && io_q && we_q && (addr_q == AddrDdr);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            addr_q      <= 16'h0000;
            wdata_q     <= 16'h0000;
            data_out_q  <= 16'h0000;
            we_q        <= 1'b0;
            io_q        <= 1'b0;
            cap_q       <= 1'b0;
            ready_q     <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= 16'h0000;
            ram_din_q   <= 16'h0000;
            kbdr_q      <= 8'h00;
            kb_full_q   <= 1'b0;
            dsp_data_q  <= 8'h00;
            dsp_valid_q <= 1'b0;
        end else begin
            ram_en_q <= 1'b0;
            ram_we_q <= 1'b0;
            ready_q  <= 1'b0;
            cap_q    <= ram_en_q;
            if (cap_q) data_out_q <= we_q ? 16'h0000 : ram_dout;

            // A character arriving during a KBDR read is kept: load wins over clear.
            if (kb_valid && (!kb_full_q || kbdr_rd)) begin
                kbdr_q    <= kb_data;
                kb_full_q <= 1'b1;
            end else if (kbdr_rd) begin
                kb_full_q <= 1'b0;
            end

            if (ddr_wr) begin
                dsp_data_q  <= wdata_q[7:0];
                dsp_valid_q <= 1'b1;
            end else if (dsp_valid_q && dsp_ready) begin
                dsp_valid_q <= 1'b0;
            end

            case (state_q)
                StIdle: begin
                    if (cpu.CS) begin
                        addr_q  <= cpu.ADDR;
                        we_q    <= cpu.WE;
                        wdata_q <= cpu.DataIn;
                        if (cpu.ADDR < IO_BASE) begin
                            io_q       <= 1'b0;
                            ram_en_q   <= 1'b1;
                            ram_we_q   <= cpu.WE;
                            ram_addr_q <= cpu.ADDR;
                            ram_din_q  <= cpu.DataIn;
                            cnt_q      <= 4'(WAIT_STATES);
                            state_q    <= StRamWait;
                        end else begin
                            io_q    <= 1'b1;
                            state_q <= StResp;
                        end
                    end
                end
                StRamWait: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q < 4'd2) state_q <= StResp;
                end
                StResp: begin
                    ready_q <= 1'b1;
                    if (io_q) data_out_q <= we_q ? 16'h0000 : io_rdata;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign cpu.DataOut = data_out_q;
    assign cpu.READY   = ready_q;
    assign ram_en      = ram_en_q;
    assign ram_we      = ram_we_q;
    assign ram_addr    = ram_addr_q;
    assign ram_din     = ram_din_q;
    assign dsp_valid   = dsp_valid_q;
    assign dsp_data    = dsp_data_q;
endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Scoreboard bench for lc3_mem_ctrl: directed scenarios plus randomized traffic checked
// against a register-level model of RAM, keyboard and display.
module tb_lc3_mem_ctrl;
    localparam int unsigned WS = 2;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    lc3_mem_ctrl_if cpu_if ();

    logic        ram_en, ram_we;
    logic [15:0] ram_addr, ram_din, ram_dout;
    logic        kb_valid = 1'b0;
    logic [7:0]  kb_data = 8'h00;
    logic        dsp_valid;
    logic [7:0]  dsp_data;
    logic        dsp_ready = 1'b0;

    lc3_mem_ctrl #(.WAIT_STATES(WS), .IO_BASE(16'hFE00)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .cpu       (cpu_if),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout),
        .kb_valid  (kb_valid),
        .kb_data   (kb_data),
        .dsp_valid (dsp_valid),
        .dsp_data  (dsp_data),
        .dsp_ready (dsp_ready)
    );

    function automatic logic [15:0] ram_init(input logic [15:0] a);
        return (a == 16'h3000) ? 16'h1234 : (a ^ 16'h5A5A);
    endfunction

    // Synchronous RAM: read data valid the cycle after ram_en.
    logic [15:0] ram [0:65535];
    bit          ram_wr [0:65535];
    always @(posedge CLK) begin
        if (ram_en === 1'b1) begin
            if (ram_we) begin
                ram[ram_addr]    <= ram_din;
                ram_wr[ram_addr] <= 1'b1;
            end
            ram_dout <= ram_wr[ram_addr] ? ram[ram_addr] : ram_init(ram_addr);
        end
    end

    int unsigned cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {logic [15:0] data; int unsigned cyc;} rdy_t;
    typedef struct {logic we; logic [15:0] addr; logic [15:0] din; int unsigned cyc;} ram_t;
    rdy_t rdy_q[$];
    ram_t ram_q[$];

    int n_pass = 0;
    int n_chk = 0;
    int ready_seen = 0;

    // Reference model state
    logic [15:0] m_mem [logic [15:0]];
    bit          m_full = 1'b0;
    logic [7:0]  m_kbdr = 8'h00;
    bit          m_dval = 1'b0;
    logic [7:0]  m_ddata = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [15:0] m_read(input logic [15:0] a);
        if (m_mem.exists(a)) return m_mem[a];
        return ram_init(a);
    endfunction

    rdy_t mr;
    ram_t mm;
    always @(negedge CLK) begin
        if (cpu_if.READY === 1'b1) begin
            ready_seen++;
            if (rdy_q.size() == 0) begin
                chk("spurious_ready", 32'(cpu_if.READY), 32'd0);
            end else begin
                mr = rdy_q.pop_front();
                chk("ready_cycle", cyc, mr.cyc);
                chk("read_data", 32'(cpu_if.DataOut), 32'(mr.data));
            end
        end
        if (ram_en === 1'b1) begin
            if (ram_q.size() == 0) begin
                chk("spurious_ram_en", 32'(ram_en), 32'd0);
            end else begin
                mm = ram_q.pop_front();
                chk("ram_en_cycle", cyc, mm.cyc);
                chk("ram_we", 32'(ram_we), 32'(mm.we));
                chk("ram_addr", 32'(ram_addr), 32'(mm.addr));
                if (mm.we) chk("ram_din", 32'(ram_din), 32'(mm.din));
            end
        end
    end

    task automatic access(input bit we, input logic [15:0] addr, input logic [15:0] din,
                          input bit kb_resp, input logic [7:0] kb_ch);
        rdy_t r;
        ram_t m;
        int   budget;
        @(negedge CLK);
        cpu_if.CS     = 1'b1;
        cpu_if.WE     = we;
        cpu_if.ADDR   = addr;
        cpu_if.DataIn = din;
        r.data = 16'h0000;
        if (addr < 16'hFE00) begin
            r.cyc = cyc + 1 + WS + 1;
            m.we = we; m.addr = addr; m.din = din; m.cyc = cyc + 1;
            ram_q.push_back(m);
            if (we) m_mem[addr] = din;
            else r.data = m_read(addr);
        end else begin
            r.cyc = cyc + 2;
            case (addr)
                16'hFE00: if (!we) r.data = {m_full, 15'b0};
                16'hFE02: if (!we) begin r.data = {8'h00, m_kbdr}; m_full = 1'b0; end
                16'hFE04: if (!we) r.data = {~m_dval, 15'b0};
                16'hFE06: if (we) begin m_dval = 1'b1; m_ddata = din[7:0]; end
                default: ;
            endcase
        end
        rdy_q.push_back(r);
        @(negedge CLK);
        cpu_if.CS     = 1'b0;
        cpu_if.WE     = 1'($urandom);
        cpu_if.ADDR   = 16'($urandom);
        cpu_if.DataIn = 16'($urandom);
        if (kb_resp) begin
            kb_valid = 1'b1;
            kb_data  = kb_ch;
            if (!m_full) begin m_kbdr = kb_ch; m_full = 1'b1; end
            @(negedge CLK);
            kb_valid = 1'b0;
        end
        budget = 40;
        while (rdy_q.size() != 0 && budget > 0) begin
            @(negedge CLK);
            budget--;
        end
        if (rdy_q.size() != 0) begin
            chk("ready_timeout", 32'(rdy_q.size()), 32'd0);
            rdy_q.delete();
        end
    endtask

    task automatic kb_strobe(input logic [7:0] ch);
        @(negedge CLK);
        kb_valid = 1'b1;
        kb_data  = ch;
        if (!m_full) begin m_kbdr = ch; m_full = 1'b1; end
        @(negedge CLK);
        kb_valid = 1'b0;
    endtask

    task automatic dsp_accept();
        @(negedge CLK);
        dsp_ready = 1'b1;
        m_dval    = 1'b0;
        @(negedge CLK);
        dsp_ready = 1'b0;
    endtask

    int rs;
    int op;
    logic [15:0] ra;
    initial begin
        cpu_if.CS = 1'b0; cpu_if.WE = 1'b0; cpu_if.ADDR = 16'h0000; cpu_if.DataIn = 16'h0000;
        repeat (3) @(negedge CLK);
        chk("rst_DataOut", 32'(cpu_if.DataOut), 32'd0);
        chk("rst_READY", 32'(cpu_if.READY), 32'd0);
        chk("rst_ram_en", 32'(ram_en), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_din", 32'(ram_din), 32'd0);
        chk("rst_dsp_valid", 32'(dsp_valid), 32'd0);
        chk("rst_dsp_data", 32'(dsp_data), 32'd0);
        RST = 1'b0;

        access(1'b0, 16'h3000, 16'h0000, 1'b0, 8'h00);
        access(1'b1, 16'h3001, 16'hBEEF, 1'b0, 8'h00);
        access(1'b0, 16'h3001, 16'h0000, 1'b0, 8'h00);

        kb_strobe(8'h41);
        access(1'b0, 16'hFE00, 16'h0000, 1'b0, 8'h00);
        access(1'b0, 16'hFE02, 16'h0000, 1'b0, 8'h00);
        access(1'b0, 16'hFE00, 16'h0000, 1'b0, 8'h00);
        kb_strobe(8'h61);
        kb_strobe(8'h62);
        access(1'b0, 16'hFE02, 16'h0000, 1'b0, 8'h00);

        access(1'b1, 16'hFE06, 16'h0058, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk("dsp_valid_hold", 32'(dsp_valid), 32'd1);
        end
        chk("dsp_data", 32'(dsp_data), 32'(m_ddata));
        access(1'b0, 16'hFE04, 16'h0000, 1'b0, 8'h00);
        dsp_accept();
        chk("dsp_valid_clear", 32'(dsp_valid), 32'd0);
        access(1'b0, 16'hFE04, 16'h0000, 1'b0, 8'h00);

        kb_strobe(8'h41);
        access(1'b0, 16'hFE02, 16'h0000, 1'b1, 8'h42);
        access(1'b0, 16'hFE00, 16'h0000, 1'b0, 8'h00);
        access(1'b0, 16'hFE02, 16'h0000, 1'b0, 8'h00);

        // Reset while a RAM read sits in its wait states.
        @(negedge CLK);
        cpu_if.CS = 1'b1; cpu_if.WE = 1'b0; cpu_if.ADDR = 16'h3005;
        mm.we = 1'b0; mm.addr = 16'h3005; mm.din = 16'h0000; mm.cyc = cyc + 1;
        ram_q.push_back(mm);
        rs = ready_seen;
        @(negedge CLK);
        cpu_if.CS = 1'b0;
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        m_full = 1'b0; m_kbdr = 8'h00; m_dval = 1'b0; m_ddata = 8'h00;
        repeat (6) @(negedge CLK);
        chk("no_ready_after_rst", 32'(ready_seen - rs), 32'd0);
        chk("ram_en_after_rst", 32'(ram_en), 32'd0);
        chk("ram_en_before_rst", 32'(ram_q.size()), 32'd0);
        access(1'b0, 16'hFFF0, 16'h0000, 1'b0, 8'h00);
        access(1'b0, 16'hFE00, 16'h0000, 1'b0, 8'h00);

        for (int i = 0; i < 200; i++) begin
            op = int'($urandom_range(0, 11));
            ra = 16'h3000 + 16'($urandom_range(0, 15));
            case (op)
                0, 1, 2: access(1'b0, ra, 16'h0000, 1'b0, 8'h00);
                3, 4:    access(1'b1, ra, 16'($urandom), 1'b0, 8'h00);
                5:       access(1'b0, 16'hFE00, 16'h0000, 1'b0, 8'h00);
                6:       access(1'b0, 16'hFE02, 16'h0000, 1'($urandom), 8'($urandom));
                7:       access(1'b0, 16'hFE04, 16'h0000, 1'b0, 8'h00);
                8:       access(1'b1, 16'hFE06, 16'($urandom), 1'b0, 8'h00);
                9:       access(1'($urandom), 16'hFE00 + 16'($urandom_range(0, 511)),
                                16'($urandom), 1'b0, 8'h00);
                10:      kb_strobe(8'($urandom));
                default: dsp_accept();
            endcase
        end
        repeat (5) @(negedge CLK);
        chk("final_dsp_valid", 32'(dsp_valid), 32'(m_dval));
        chk("ram_queue_drained", 32'(ram_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
